pe_operand_loader: RTL and testbench
====================================

# pe_operand_loader

Upstream feeder for the 16-input multi-precision dot-product PE. Accepts A/B operands as a stream of 64-bit beats, assembles 256-bit A and B vectors in a two-slot ping-pong buffer, and issues one vector per cycle to the PE's `mode_sel`/`A`/`B` inputs. Drives `mode_sel = 2'b11` (set zero) on every idle cycle. Tracks in-flight vectors with a latency-matched valid/mode pipe, so consumers know which PE `result` cycles carry real data.

## Interface
- `PE_LAT`, default 4: PE latency, from the cycle `A`/`B`/`mode_sel` are presented to the cycle `result` is valid. Four stages: input register plus three pipeline stages.
- `BEATS`, default 4: number of 64-bit beats per 256-bit vector. Fixed at 4; the parameter is for documentation and assertions only.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: beat valid.
- `in_ready` output 1: beat accepted when `in_valid & in_ready` (handshake).
- `in_a` input 64: A beat.
- `in_b` input 64: B beat.
- `in_mode` input 2: precision. 00 = FP16, 01 = FP32, 10 = FP64, 11 = zero.
- `in_last` input 1: final beat of the vector.
- `issue_en` input 1: permits issue this cycle. When 0, pending vectors are held.
- `pe_mode_sel` output 2: to the PE `mode_sel` input; registered.
- `pe_A` output 256: to the PE `A` input; registered.
- `pe_B` output 256: to the PE `B` input; registered.
- `res_valid` output 1: the PE `result` in this cycle belongs to an issued vector.
- `res_mode` output 2: mode of that vector.
- `err_mode` output 1: sticky; a beat's `in_mode` differed from beat 0 of the same vector.

## Operation
- **Slots.** Two slots. Each slot holds A[255:0], B[255:0], mode[1:0] and a `pend` bit.
- **Pointers.** `wr_ptr` selects the filling slot and `rd_ptr` the issuing slot. `beat_cnt` is 2 bits.
- **Beat write.** On a handshake, the beat is written to slot `wr_ptr` at bits [64k+63:64k], where k = `beat_cnt`.
  - Beat 0 clears the slot's A and B to zero and captures `in_mode`.
  - On beats 1–3, `in_mode` ≠ the captured mode sets `err_mode`. The data is still accepted, and the captured mode is kept.
- **Vector close.** A vector closes on a handshake with `in_last`, or on the 4th beat (`beat_cnt` == 3) even if `in_last` = 0.
  - Early `in_last` (beat k < 3) leaves beats k+1..3 as zero (zero padding).
  - On close: set `pend[wr_ptr]`, toggle `wr_ptr`, set `beat_cnt` = 0.
- **Ready.** `in_ready = ~pend[wr_ptr]`, taken from registered state only; there is no combinational path from `issue_en`.
- **Issue.** Each cycle, if `pend[rd_ptr] & issue_en`:
  - Register the slot's A, B and mode onto `pe_A`, `pe_B`, `pe_mode_sel`.
  - Clear `pend[rd_ptr]` and toggle `rd_ptr`.
  - Otherwise register `pe_mode_sel = 2'b11` and leave `pe_A`/`pe_B` at their previous values.
- **Back-to-back issue.** One vector per cycle maximum. Consecutive pending slots issue in consecutive cycles.
- **Same slot written and freed.** If a slot is freed by issue and also targeted by a write in the same cycle, the write is blocked that cycle, because `in_ready` comes from pre-edge state. The beat is accepted the next cycle.
- **Result tracking.** A `PE_LAT`-deep shift register carries (issued, mode).
  - `res_valid`/`res_mode` are the tail of the shift register.
  - In cycles without issue, a 0 is shifted in.
- **Mode 11 input.** A vector with mode 11 issues normally and produces `res_valid` = 1 (the PE result is zero).

## Timing
- **Reset values.** `in_ready`=1, `pe_mode_sel`=2'b11, `pe_A`=0, `pe_B`=0, `res_valid`=0, `res_mode`=0, `err_mode`=0.
- **State cleared by reset.** Both `pend`=0, pointers=0, `beat_cnt`=0, shift register=0.
- **Reset mid-operation.** A partial vector and any pending vectors are discarded, and in-flight `res_valid` bits are dropped.
- **Issue latency.** Closing beat handshaked in cycle N, with `issue_en`=1 → the vector appears on `pe_*` in cycle N+2, and lasts exactly one cycle.
- **Result latency.** Vector on `pe_*` in cycle M → `res_valid`=1 in cycle M+`PE_LAT`.
- **Throughput.** Sustained throughput is one vector per 4 beat-cycles, with no bubbles on input while `issue_en`=1.
- **Full.** Both slots pending → `in_ready`=0 until an issue occurs. `in_ready` returns in the cycle after the issue edge.

## Test plan
- **Single FP16 vector.** After reset, send 4 beats with `in_a`=k+1, `in_b`=0x10+k and mode 00; last beat in cycle 3.
  - Cycle 5: `pe_mode_sel`=00, `pe_A`={4,3,2,1}×64-bit, `pe_B`={0x13,0x12,0x11,0x10}.
  - Cycle 9: `res_valid`=1 with `res_mode`=00.
  - All other cycles: `pe_mode_sel`=11.
- **Early `in_last`.** FP64 vector, 2 beats with `in_last` on beat 1 → `pe_A`[255:128]=0 and `pe_B`[255:128]=0; `pe_mode_sel`=10 for one cycle.
- **Backpressure.** Hold `issue_en`=0 and stream 3 vectors.
  - `in_ready` drops after the 8th beat; the 9th beat stalls.
  - Raise `issue_en`: vectors issue in consecutive cycles in order, and the stalled beat is accepted the cycle after the first issue.
- **Mode mismatch.** Beat 0 mode 01, beat 2 mode 00 → `err_mode`=1 and stays 1; the vector still issues with `pe_mode_sel`=01.
- **Reset mid-stream.** Assert `rst` after beat 2 of a vector while one vector is in flight in the PE.
  - Next cycle: `in_ready`=1, `pe_mode_sel`=11.
  - `res_valid` stays 0 for the next `PE_LAT` cycles.
  - A fresh vector then issues correctly.

Source files
------------

// File: rtl/pe_operand_loader.sv
// pe_operand_loader
//   Feeds the 16-input multi-precision dot-product PE. It collects 64-bit A/B
//   beats into 256-bit vectors held in a two-slot ping-pong buffer. It issues
//   at most one vector per cycle onto the PE inputs. On idle cycles it drives
//   mode_sel = 2'b11 (zero). A PE_LAT-deep valid/mode pipe marks which PE
//   result cycles carry issued vectors.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : beat handshake (in_ready depends only on registered state)
//   in_a, in_b      : 64-bit A/B beat; beat k lands at bits [64k+63:64k]
//   in_mode         : precision (00 FP16, 01 FP32, 10 FP64, 11 zero)
//   in_last         : final beat of the vector (early last zero-pads the rest)
//   issue_en        : allow issue this cycle
//   pe_mode_sel     : registered PE mode_sel
//   pe_A, pe_B      : registered PE operand vectors
//   res_valid       : PE result this cycle belongs to an issued vector
//   res_mode        : mode of that vector
//   err_mode        : sticky; a beat's mode differed from beat 0 of its vector
module pe_operand_loader #(
   parameter int PE_LAT = 4,
   parameter int BEATS  = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [63:0]  in_a,
   input  logic [63:0]  in_b,
   input  logic [1:0]   in_mode,
   input  logic         in_last,
   input  logic         issue_en,
   output logic [1:0]   pe_mode_sel,
   output logic [255:0] pe_A,
   output logic [255:0] pe_B,
   output logic         res_valid,
   output logic [1:0]   res_mode,
   output logic         err_mode
);

   localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);
   localparam logic [1:0] MODE_ZERO = 2'b11;

   // control state
   logic              wr_ptr_q, wr_ptr_d;
   logic              rd_ptr_q, rd_ptr_d;
   logic [1:0]        beat_cnt_q, beat_cnt_d;
   logic [1:0]        pend_q, pend_d;
   logic              err_mode_q, err_mode_d;

   // slot storage (data only, never reset)
   logic [255:0]      slot_a_q [2];
   logic [255:0]      slot_a_d [2];
   logic [255:0]      slot_b_q [2];
   logic [255:0]      slot_b_d [2];
   logic [1:0]        slot_mode_q [2];
   logic [1:0]        slot_mode_d [2];

   // issue stage registers
   logic [1:0]        pe_mode_q, pe_mode_d;
   logic [255:0]      pe_a_q, pe_a_d;
   logic [255:0]      pe_b_q, pe_b_d;
   logic              vld_p0_q, vld_p0_d;

   // result tracking pipe
   logic [PE_LAT-1:0] res_vld_sr_q, res_vld_sr_d;
   logic [1:0]        res_mode_sr_q [PE_LAT];
   logic [1:0]        res_mode_sr_d [PE_LAT];

   logic              accept;
   logic              issue;
   logic              close;

   assign in_ready = ~pend_q[wr_ptr_q];
   assign accept   = in_valid & in_ready;
   assign issue    = pend_q[rd_ptr_q] & issue_en;
   assign close    = accept & (in_last | (beat_cnt_q == LAST_BEAT));

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      beat_cnt_d   = beat_cnt_q;
      pend_d       = pend_q;
      err_mode_d   = err_mode_q;
      slot_a_d     = slot_a_q;
      slot_b_d     = slot_b_q;
      slot_mode_d  = slot_mode_q;
      pe_mode_d    = MODE_ZERO;
      pe_a_d       = pe_a_q;
      pe_b_d       = pe_b_q;
      vld_p0_d     = 1'b0;
      res_vld_sr_d = '0;
      res_mode_sr_d = '{default: 2'b00};

      // ---- stage: beat assembly into the filling slot ----
      if (accept) begin
         if (beat_cnt_q == 2'd0) begin
            // Clearing on beat 0 is what gives zero padding on early in_last.
            slot_a_d[wr_ptr_q]    = '0;
            slot_b_d[wr_ptr_q]    = '0;
            slot_mode_d[wr_ptr_q] = in_mode;
         end else if (in_mode != slot_mode_q[wr_ptr_q]) begin
            err_mode_d = 1'b1;
         end
         slot_a_d[wr_ptr_q][{beat_cnt_q, 6'b0} +: 64] = in_a;
         slot_b_d[wr_ptr_q][{beat_cnt_q, 6'b0} +: 64] = in_b;
         beat_cnt_d = beat_cnt_q + 2'd1;
      end

      // pend[wr_ptr] is 0 whenever a beat is accepted and pend[rd_ptr] is 1
      // whenever an issue happens, so close and issue never touch the same slot.
      if (close) begin
         pend_d[wr_ptr_q] = 1'b1;
         wr_ptr_d         = ~wr_ptr_q;
         beat_cnt_d       = 2'd0;
      end

      // ---- stage p0: issue onto the PE inputs ----
      if (issue) begin
         pe_a_d           = slot_a_q[rd_ptr_q];
         pe_b_d           = slot_b_q[rd_ptr_q];
         pe_mode_d        = slot_mode_q[rd_ptr_q];
         vld_p0_d         = 1'b1;
         pend_d[rd_ptr_q] = 1'b0;
         rd_ptr_d         = ~rd_ptr_q;
      end

      // ---- stages p1..pPE_LAT: follow the vector through the PE ----
      // pe_mode_q is 2'b11 on idle cycles, so the mode is gated by vld_p0.
      res_vld_sr_d[0]  = vld_p0_q;
      res_mode_sr_d[0] = vld_p0_q ? pe_mode_q : 2'b00;
      for (int i = 1; i < PE_LAT; i++) begin
         res_vld_sr_d[i]  = res_vld_sr_q[i-1];
         res_mode_sr_d[i] = res_mode_sr_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q      <= 1'b0;
         rd_ptr_q      <= 1'b0;
         beat_cnt_q    <= 2'd0;
         pend_q        <= 2'b00;
         err_mode_q    <= 1'b0;
         pe_mode_q     <= MODE_ZERO;
         pe_a_q        <= '0;
         pe_b_q        <= '0;
         vld_p0_q      <= 1'b0;
         res_vld_sr_q  <= '0;
         res_mode_sr_q <= '{default: 2'b00};
      end else begin
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         beat_cnt_q    <= beat_cnt_d;
         pend_q        <= pend_d;
         err_mode_q    <= err_mode_d;
         pe_mode_q     <= pe_mode_d;
         pe_a_q        <= pe_a_d;
         pe_b_q        <= pe_b_d;
         vld_p0_q      <= vld_p0_d;
         res_vld_sr_q  <= res_vld_sr_d;
         res_mode_sr_q <= res_mode_sr_d;
      end
   end

   // Slot contents are only meaningful while pend is set or a fill is under
   // way, and both are cleared by reset, so the storage itself is not reset.
   always_ff @(posedge clk) begin
      slot_a_q    <= slot_a_d;
      slot_b_q    <= slot_b_d;
      slot_mode_q <= slot_mode_d;
   end

   assign pe_mode_sel = pe_mode_q;
   assign pe_A        = pe_a_q;
   assign pe_B        = pe_b_q;
   assign res_valid   = res_vld_sr_q[PE_LAT-1];
   assign res_mode    = res_mode_sr_q[PE_LAT-1];
   assign err_mode    = err_mode_q;

endmodule

// File: tb/tb_pe_operand_loader.sv
// tb_pe_operand_loader
//   Directed bench for pe_operand_loader. Inputs change 1 time unit after a
//   rising edge, and outputs are sampled at that same point. "Cycle c" is the
//   interval between edge c and edge c+1.
module tb_pe_operand_loader;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [63:0]  in_a;
   logic [63:0]  in_b;
   logic [1:0]   in_mode;
   logic         in_last;
   logic         issue_en;
   logic [1:0]   pe_mode_sel;
   logic [255:0] pe_A;
   logic [255:0] pe_B;
   logic         res_valid;
   logic [1:0]   res_mode;
   logic         err_mode;

   int n_chk  = 0;
   int n_pass = 0;

   pe_operand_loader #(.PE_LAT(4), .BEATS(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_mode     (in_mode),
      .in_last     (in_last),
      .issue_en    (issue_en),
      .pe_mode_sel (pe_mode_sel),
      .pe_A        (pe_A),
      .pe_B        (pe_B),
      .res_valid   (res_valid),
      .res_mode    (res_mode),
      .err_mode    (err_mode)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic beat(input logic [63:0] a, input logic [63:0] b,
                       input logic [1:0] m, input logic l);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_mode  = m;
      in_last  = l;
   endtask

   task automatic idle();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   initial begin
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_mode  = 2'b00;
      in_last  = 1'b0;
      issue_en = 1'b1;
      tick();
      tick();

      // reset values
      chk("rst_in_ready", 256'(in_ready), 256'(1'b1));
      chk("rst_pe_mode", 256'(pe_mode_sel), 256'(2'b11));
      chk("rst_pe_A", pe_A, 256'd0);
      chk("rst_pe_B", pe_B, 256'd0);
      chk("rst_res_valid", 256'(res_valid), 256'(1'b0));
      chk("rst_res_mode", 256'(res_mode), 256'(2'b00));
      chk("rst_err_mode", 256'(err_mode), 256'(1'b0));
      rst = 1'b0;

      // single FP16 vector: beats in cycles 0..3
      for (int k = 0; k < 4; k++) begin
         beat(64'(k + 1), 64'(16 + k), 2'b00, k == 3);
         chk("fp16_idle_mode", 256'(pe_mode_sel), 256'(2'b11));
         tick();
      end
      idle();                                            // cycle 4
      chk("fp16_c4_mode", 256'(pe_mode_sel), 256'(2'b11));
      chk("fp16_c4_ready", 256'(in_ready), 256'(1'b1));
      tick();                                            // cycle 5
      chk("fp16_c5_mode", 256'(pe_mode_sel), 256'(2'b00));
      chk("fp16_c5_A", pe_A, {64'd4, 64'd3, 64'd2, 64'd1});
      chk("fp16_c5_B", pe_B, {64'h13, 64'h12, 64'h11, 64'h10});
      chk("fp16_c5_res_valid", 256'(res_valid), 256'(1'b0));
      tick();                                            // cycle 6
      chk("fp16_c6_mode", 256'(pe_mode_sel), 256'(2'b11));
      chk("fp16_c6_A_hold", pe_A, {64'd4, 64'd3, 64'd2, 64'd1});
      for (int c = 6; c < 9; c++) begin
         chk("fp16_pre_res_valid", 256'(res_valid), 256'(1'b0));
         tick();
      end
      chk("fp16_c9_res_valid", 256'(res_valid), 256'(1'b1));   // cycle 9
      chk("fp16_c9_res_mode", 256'(res_mode), 256'(2'b00));
      tick();
      chk("fp16_c10_res_valid", 256'(res_valid), 256'(1'b0));

      // mode mismatch on beat 2; vector closes on the 4th beat without in_last
      beat(64'h100, 64'h200, 2'b01, 1'b0);
      tick();
      beat(64'h101, 64'h201, 2'b01, 1'b0);
      chk("mm_err_before", 256'(err_mode), 256'(1'b0));
      tick();
      beat(64'h102, 64'h202, 2'b00, 1'b0);
      tick();
      chk("mm_err_set", 256'(err_mode), 256'(1'b1));
      beat(64'h103, 64'h203, 2'b01, 1'b0);
      tick();
      idle();
      chk("mm_idle_mode", 256'(pe_mode_sel), 256'(2'b11));
      tick();
      chk("mm_mode", 256'(pe_mode_sel), 256'(2'b01));
      chk("mm_A", pe_A, {64'h103, 64'h102, 64'h101, 64'h100});
      chk("mm_B", pe_B, {64'h203, 64'h202, 64'h201, 64'h200});

      // early in_last, FP64, into the slot that held the FP16 vector
      beat(64'hA0, 64'hB0, 2'b10, 1'b0);
      tick();
      beat(64'hA1, 64'hB1, 2'b10, 1'b1);
      tick();
      idle();
      chk("early_idle_mode", 256'(pe_mode_sel), 256'(2'b11));
      tick();                                            // vector on pe (M)
      chk("early_mode", 256'(pe_mode_sel), 256'(2'b10));
      chk("early_A", pe_A, {128'd0, 64'hA1, 64'hA0});
      chk("early_B", pe_B, {128'd0, 64'hB1, 64'hB0});
      tick();                                            // M+1
      chk("early_one_cycle", 256'(pe_mode_sel), 256'(2'b11));
      chk("mm_err_sticky", 256'(err_mode), 256'(1'b1));
      tick();
      tick();
      tick();                                            // M+4
      chk("early_res_valid", 256'(res_valid), 256'(1'b1));
      chk("early_res_mode", 256'(res_mode), 256'(2'b10));
      tick();

      // backpressure: issue held off, three vectors streamed
      issue_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         beat(64'h1000 + 64'(i), 64'h2000 + 64'(i), 2'(i / 4), (i % 4) == 3);
         chk("bp_ready_fill", 256'(in_ready), 256'(1'b1));
         tick();
      end
      beat(64'h1008, 64'h2008, 2'b10, 1'b0);
      chk("bp_ready_full0", 256'(in_ready), 256'(1'b0));
      tick();
      chk("bp_ready_full1", 256'(in_ready), 256'(1'b0));
      chk("bp_no_issue", 256'(pe_mode_sel), 256'(2'b11));
      issue_en = 1'b1;                                   // cycle X
      tick();                                            // X+1
      chk("bp_ready_back", 256'(in_ready), 256'(1'b1));
      chk("bp_v0_mode", 256'(pe_mode_sel), 256'(2'b00));
      chk("bp_v0_A", pe_A, {64'h1003, 64'h1002, 64'h1001, 64'h1000});
      tick();                                            // X+2
      chk("bp_v1_mode", 256'(pe_mode_sel), 256'(2'b01));
      chk("bp_v1_A", pe_A, {64'h1007, 64'h1006, 64'h1005, 64'h1004});
      chk("bp_v1_B", pe_B, {64'h2007, 64'h2006, 64'h2005, 64'h2004});
      for (int i = 9; i < 12; i++) begin
         beat(64'h1000 + 64'(i), 64'h2000 + 64'(i), 2'b10, i == 11);
         tick();
      end
      idle();                                            // X+5
      chk("bp_v2_wait_mode", 256'(pe_mode_sel), 256'(2'b11));
      chk("bp_v0_res_valid", 256'(res_valid), 256'(1'b1));
      chk("bp_v0_res_mode", 256'(res_mode), 256'(2'b00));
      tick();                                            // X+6
      chk("bp_v2_mode", 256'(pe_mode_sel), 256'(2'b10));
      chk("bp_v2_A", pe_A, {64'h100B, 64'h100A, 64'h1009, 64'h1008});
      chk("bp_v2_B", pe_B, {64'h200B, 64'h200A, 64'h2009, 64'h2008});
      chk("bp_v1_res_valid", 256'(res_valid), 256'(1'b1));
      chk("bp_v1_res_mode", 256'(res_mode), 256'(2'b01));
      tick();
      chk("bp_gap_res_valid", 256'(res_valid), 256'(1'b0));
      tick();
      tick();
      tick();                                            // X+10
      chk("bp_v2_res_valid", 256'(res_valid), 256'(1'b1));
      chk("bp_v2_res_mode", 256'(res_mode), 256'(2'b10));
      tick();

      // reset mid-stream: vector V in the PE, partial vector of 3 beats
      for (int k = 0; k < 4; k++) begin                  // r0..r3
         beat(64'h2800 + 64'(k), 64'h2900 + 64'(k), 2'b01, k == 3);
         tick();
      end
      for (int k = 0; k < 3; k++) begin                  // r4..r6
         beat(64'h5500 + 64'(k), 64'h5600 + 64'(k), 2'b00, 1'b0);
         if (k == 1) begin
            chk("rs_v_mode", 256'(pe_mode_sel), 256'(2'b01));
            chk("rs_v_A", pe_A, {64'h2803, 64'h2802, 64'h2801, 64'h2800});
         end
         tick();
      end
      idle();                                            // r7
      rst = 1'b1;
      tick();                                            // r8
      chk("rs_ready", 256'(in_ready), 256'(1'b1));
      chk("rs_mode", 256'(pe_mode_sel), 256'(2'b11));
      chk("rs_A", pe_A, 256'd0);
      chk("rs_err_cleared", 256'(err_mode), 256'(1'b0));
      rst = 1'b0;
      for (int k = 0; k < 3; k++) begin                  // r8..r10
         beat(64'h3000 + 64'(k), 64'h3100 + 64'(k), 2'b00, k == 2);
         chk("rs_res_dropped", 256'(res_valid), 256'(1'b0));
         tick();
      end
      idle();                                            // r11
      chk("rs_res_dropped_r11", 256'(res_valid), 256'(1'b0));
      tick();                                            // r12
      chk("rs_fresh_mode", 256'(pe_mode_sel), 256'(2'b00));
      chk("rs_fresh_A", pe_A, {64'd0, 64'h3002, 64'h3001, 64'h3000});
      chk("rs_fresh_B", pe_B, {64'd0, 64'h3102, 64'h3101, 64'h3100});
      tick();
      tick();
      tick();
      tick();                                            // r16
      chk("rs_fresh_res_valid", 256'(res_valid), 256'(1'b1));
      chk("rs_fresh_res_mode", 256'(res_mode), 256'(2'b00));
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
